// File: rtl/hex_keypad_reader_pkg.sv
// Shared types and constants for the hex keypad reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hex_keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  // Debounce/hold tracking state, stepped once per scan frame
  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_HELD,
    S_RELEASE
  } state_t;

  // Outcome of one full 4-column scan
  typedef enum logic [1:0] {
    NONE,
    KEY,
    MULTI
  } frame_res_t;

  // Key legend, row-major: index = 4*row + col
  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

endpackage

// File: rtl/hex_keypad_reader_if.sv
// Byte output channel of the keypad reader: byte, valid/ready, overrun flag.
// Latency: n/a (wiring only).
// Backpressure: producer holds o_byte/o_valid until i_ready is seen.
interface hex_keypad_reader_if;
  logic [7:0] o_byte;
  logic       o_valid;
  logic       i_ready;
  logic       o_overrun;

  modport master (output o_byte, output o_valid, output o_overrun, input i_ready);
  modport slave  (input o_byte, input o_valid, input o_overrun, output i_ready);
endinterface

// File: rtl/hex_keypad_reader_scan.sv
// Keypad matrix scanner: row sync, column drive, dwell timing, per-frame decode.
// Latency: rows seen 2 cycles after change; result valid on frame-end strobe.
// Backpressure: none; free-running scan.
module keypad_scan
  import hex_keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50_000
) (
  input  logic                i_clock,
  input  logic                i_reset,
  output logic [NUM_COLS-1:0] o_col,
  input  logic [NUM_ROWS-1:0] i_row,
  output logic                frame_end_o,
  output frame_res_t          result_o,
  output logic [3:0]          key_o
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [NUM_ROWS-1:0] row_meta_q, row_sync_q;
  logic [DW-1:0]       dwell_q, dwell_d;
  logic [1:0]          col_idx_q, col_idx_d;
  logic [1:0]          hits_q, hits_d;   // low rows seen so far this frame, saturates at 2
  logic [3:0]          idx_q, idx_d;     // matrix index of the last single hit
  logic                sample;
  logic [2:0]          col_hits, tot;
  logic [1:0]          col_row;
  logic [3:0]          key_idx;

  assign o_col = ~(4'b0001 << col_idx_q);

  // Dwell/column stepping, row decode of the current column and frame accumulation
  always_comb begin
    sample      = (dwell_q == DW'(SCAN_DIV - 1));
    frame_end_o = sample && (col_idx_q == 2'd3);
    dwell_d     = sample ? '0 : dwell_q + 1'b1;
    col_idx_d   = sample ? col_idx_q + 2'd1 : col_idx_q;
    col_hits    = '0;
    col_row     = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!row_sync_q[r]) begin
        col_hits = col_hits + 3'd1;
        col_row  = 2'(r);
      end
    end
    tot     = {1'b0, hits_q} + col_hits;
    key_idx = (col_hits == 3'd1) ? {col_row, col_idx_q} : idx_q;
    hits_d  = hits_q;
    idx_d   = idx_q;
    if (sample) begin
      if (frame_end_o) begin
        hits_d = '0;
        idx_d  = '0;
      end else begin
        hits_d = (tot >= 3'd2) ? 2'd2 : tot[1:0];
        idx_d  = key_idx;
      end
    end
    if (tot == 3'd0)      result_o = NONE;
    else if (tot == 3'd1) result_o = KEY;
    else                  result_o = MULTI;
    key_o = KEYMAP[key_idx];
  end

  // Synchronizer and scan state registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
      dwell_q    <= '0;
      col_idx_q  <= '0;
      hits_q     <= '0;
      idx_q      <= '0;
    end else begin
      row_meta_q <= i_row;
      row_sync_q <= row_meta_q;
      dwell_q    <= dwell_d;
      col_idx_q  <= col_idx_d;
      hits_q     <= hits_d;
      idx_q      <= idx_d;
    end
  end

endmodule

// File: rtl/hex_keypad_reader.sv
// Hex keypad reader: debounces scanned keys and packs two nibbles into a byte.
// Latency: byte/valid update one cycle after the accepting frame-end cycle.
// Backpressure: while o_valid is high, newly accepted keys are dropped with o_overrun.
module hex_keypad_reader
  import hex_keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                i_clock,
  input  logic                i_reset,
  output logic [NUM_COLS-1:0] o_col,
  input  logic [NUM_ROWS-1:0] i_row,
  hex_keypad_reader_if.master bus
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  logic       frame_end;
  frame_res_t res;
  logic [3:0] key;

  state_t     state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic       accept;
  logic       phase_q, phase_d;
  logic [3:0] hi_q, hi_d;
  logic [7:0] byte_q, byte_d;
  logic       valid_q, valid_d;
  logic       overrun_q, overrun_d;

  keypad_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .o_col       (o_col),
    .i_row       (i_row),
    .frame_end_o (frame_end),
    .result_o    (res),
    .key_o       (key)
  );

  // Debounce FSM next state; steps only on frame ends, MULTI acts like NONE
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    cnt_inc = cnt_q + 1'b1;
    if (frame_end) begin
      unique case (state_q)
        S_IDLE: begin
          if (res == KEY) begin
            cand_d  = key;
            cnt_d   = CW'(1);
            state_d = S_DEBOUNCE;
          end
        end
        S_DEBOUNCE: begin
          if (res == KEY && key == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
              accept  = 1'b1;
              state_d = S_HELD;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_HELD: begin
          if (res != KEY) begin
            cnt_d   = CW'(1);
            state_d = S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (res == KEY) begin
            state_d = S_HELD;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CW'(DEBOUNCE_SCANS)) state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Nibble packing and handshake; accept sees o_valid before this cycle's clear
  always_comb begin
    phase_d   = phase_q;
    hi_d      = hi_q;
    byte_d    = byte_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (valid_q && bus.i_ready) valid_d = 1'b0;
    if (accept) begin
      if (valid_q) begin
        overrun_d = 1'b1;
      end else if (!phase_q) begin
        hi_d    = cand_q;
        phase_d = 1'b1;
      end else begin
        byte_d  = {hi_q, cand_q};
        valid_d = 1'b1;
        phase_d = 1'b0;
      end
    end
  end

  // State registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
      hi_q      <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      hi_q      <= hi_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.o_byte    = byte_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_overrun = overrun_q;

endmodule

// File: tb/tb_hex_keypad_reader.sv
// Bench for hex_keypad_reader: frame-level key model plus table and directed sequences.
// Latency: checks every cycle, #1 after the rising edge.
// Backpressure: i_ready held low, pulsed, or randomized per sequence.
module tb_hex_keypad_reader;

  localparam int SD = 8;
  localparam int DS = 3;
  localparam int FL = 4 * SD;
  localparam logic [3:0] KM [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD
  };

  typedef struct {
    int         pa;
    int         pb;
    logic [7:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] mask = '0;

  hex_keypad_reader_if bus_if ();

  hex_keypad_reader #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .o_col   (col),
    .i_row   (row),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  // Pressed switches short the driven column onto their row
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col[c] && mask[4*r+c]) row[r] = 1'b0;
  end

  // Reference model state (frame-level view)
  int         m_ph, m_run, m_quiet;
  bit         m_locked, m_phase, m_vld, m_ov;
  logic [3:0] m_rkey, m_hi;
  logic [7:0] m_byte;
  int         total = 0;
  int         bad = 0;
  int         ov_seen = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int         n;
    logic [3:0] k;
    bit         acc;
    bit         nv, nov;
    acc = 0;
    k   = '0;
    if (rst) begin
      m_ph = 0; m_run = 0; m_quiet = 0; m_locked = 0; m_rkey = '0;
      m_hi = '0; m_phase = 0; m_byte = '0; m_vld = 0; m_ov = 0;
    end else begin
      if (m_ph == FL - 1) begin
        n = $countones(mask);
        for (int i = 0; i < 16; i++) if (mask[i]) k = KM[i];
        if (!m_locked) begin
          if (n == 1 && m_run > 0 && k == m_rkey) m_run++;
          else if (n == 1 && m_run == 0) begin
            m_rkey = k;
            m_run  = 1;
          end else m_run = 0;
          if (m_run == DS) begin
            acc = 1; m_locked = 1; m_quiet = 0; m_run = 0;
          end
        end else begin
          if (n == 1) m_quiet = 0;
          else m_quiet++;
          if (m_quiet == DS) begin
            m_locked = 0;
            m_quiet  = 0;
          end
        end
      end
      nv  = m_vld;
      nov = 0;
      if (m_vld && bus_if.i_ready) nv = 0;
      if (acc) begin
        if (m_vld) nov = 1;
        else if (!m_phase) begin
          m_hi = m_rkey;
          m_phase = 1;
        end else begin
          m_byte = {m_hi, m_rkey};
          nv = 1;
          m_phase = 0;
        end
      end
      m_vld = nv;
      m_ov  = nov;
      m_ph  = (m_ph + 1) % FL;
    end
  endtask

  task automatic tick();
    logic [3:0] ec;
    @(posedge clk);
    model_edge();
    #1;
    ec = ~(4'b0001 << (m_ph / SD));
    chk("col", {4'h0, col}, {4'h0, ec});
    chk("valid", {7'h0, bus_if.o_valid}, {7'h0, m_vld});
    chk("byte", bus_if.o_byte, m_byte);
    chk("overrun", {7'h0, bus_if.o_overrun}, {7'h0, m_ov});
    if (bus_if.o_overrun) ov_seen++;
  endtask

  // mode 0: ready low; 1: random ready; 2: one ready pulse early in first frame
  task automatic run_frames(input logic [15:0] m, input int n, input int mode);
    for (int f = 0; f < n; f++) begin
      mask = m;
      for (int i = 0; i < FL; i++) begin
        case (mode)
          1:       bus_if.i_ready = ($urandom_range(0, 3) == 0);
          2:       bus_if.i_ready = (f == 0 && i == 5);
          default: bus_if.i_ready = 1'b0;
        endcase
        tick();
      end
    end
    bus_if.i_ready = 1'b0;
  endtask

  task automatic press(input int pos);
    run_frames(16'h1 << pos, DS, 0);
    run_frames('0, DS + 1, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_col"}, {4'h0, col}, 8'h0E);
    chk({tag, "_byte"}, bus_if.o_byte, 8'h00);
    chk({tag, "_valid"}, {7'h0, bus_if.o_valid}, 8'h00);
    chk({tag, "_ovr"}, {7'h0, bus_if.o_overrun}, 8'h00);
  endtask

  vec_t tbl [5];

  initial begin
    int          ov0;
    logic [15:0] prev, cur;
    int          p1, p2, sel;
    tbl[0] = '{4, 1, 8'h42};
    tbl[1] = '{12, 14, 8'hEF};
    tbl[2] = '{13, 6, 8'h06};
    tbl[3] = '{11, 2, 8'hC3};
    tbl[4] = '{3, 15, 8'hAD};

    bus_if.i_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_reset_vals("reset");
    run_frames('0, 2, 0);

    // basic byte with i_ready low
    run_frames(16'h1 << 4, 4, 0);
    run_frames('0, 4, 0);
    run_frames(16'h1 << 1, 4, 0);
    run_frames('0, 1, 0);
    chk("basic_byte", bus_if.o_byte, 8'h42);
    chk("basic_valid", {7'h0, bus_if.o_valid}, 8'h01);
    run_frames('0, 2, 0);
    chk("basic_hold", bus_if.o_byte, 8'h42);
    run_frames('0, 1, 2);
    chk("basic_clear", {7'h0, bus_if.o_valid}, 8'h00);
    chk("basic_keep", bus_if.o_byte, 8'h42);
    run_frames('0, DS, 0);

    // table of key pairs
    for (int v = 0; v < 5; v++) begin
      press(tbl[v].pa);
      press(tbl[v].pb);
      chk("tbl_byte", bus_if.o_byte, tbl[v].exp);
      chk("tbl_valid", {7'h0, bus_if.o_valid}, 8'h01);
      run_frames('0, 1, 2);
      chk("tbl_clear", {7'h0, bus_if.o_valid}, 8'h00);
    end

    // bounce rejection on r1c1
    run_frames(16'h1 << 5, 2, 0);
    run_frames('0, 1, 0);
    run_frames(16'h1 << 5, 2, 0);
    run_frames('0, 1, 0);
    chk("bounce_noacc", {7'h0, bus_if.o_valid}, 8'h00);
    press(5);
    press(0);
    chk("bounce_byte", bus_if.o_byte, 8'h51);
    run_frames('0, 1, 2);

    // two keys together, then one released
    run_frames(16'h0401, 6, 0);
    run_frames(16'h0001, DS, 0);
    run_frames('0, DS + 1, 0);
    press(9);
    chk("multi_byte", bus_if.o_byte, 8'h18);
    run_frames('0, 1, 2);

    // long hold gives one nibble
    run_frames(16'h1 << 15, 20, 0);
    run_frames('0, DS + 1, 0);
    press(0);
    chk("held_byte", bus_if.o_byte, 8'hD1);
    run_frames('0, 1, 2);

    // overrun with AB pending
    press(3);
    press(7);
    chk("ovr_pend", bus_if.o_byte, 8'hAB);
    ov0 = ov_seen;
    press(5);
    chk("ovr_pulses", 8'(ov_seen - ov0), 8'h01);
    chk("ovr_byte", bus_if.o_byte, 8'hAB);
    chk("ovr_valid", {7'h0, bus_if.o_valid}, 8'h01);
    run_frames('0, 1, 2);
    press(6);
    press(10);
    chk("ovr_phase", bus_if.o_byte, 8'h69);
    run_frames('0, 1, 2);

    // reset after first nibble, mid-frame
    run_frames(16'h1 << 8, DS, 0);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    chk_reset_vals("midrst");
    rst  = 1'b0;
    mask = '0;
    run_frames('0, 2, 0);
    press(8);
    press(9);
    chk("midrst_byte", bus_if.o_byte, 8'h78);
    run_frames('0, 1, 2);

    // randomized key frames and ready against the model
    prev = '0;
    for (int f = 0; f < 80; f++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) cur = prev;
      else if (sel < 6) cur = '0;
      else if (sel < 9) cur = 16'h1 << $urandom_range(0, 15);
      else begin
        p1  = $urandom_range(0, 15);
        p2  = (p1 + 1 + $urandom_range(0, 14)) % 16;
        cur = (16'h1 << p1) | (16'h1 << p2);
      end
      run_frames(cur, 1, 1);
      prev = cur;
    end
    run_frames('0, DS + 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
